// File: rtl/buzzer_tone_driver_pkg.sv
// Shared types and defaults for the piezo tone driver.
// Holds the FSM state enum, channel codes and the enable priority encoder.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam logic [1:0] CH_NONE = 2'd0;
  localparam logic [1:0] CH1     = 2'd1;
  localparam logic [1:0] CH2     = 2'd2;
  localparam logic [1:0] CH3     = 2'd3;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_HALF1    = 3;
  localparam int DEF_HALF2    = 5;
  localparam int DEF_HALF3    = 7;
  localparam int DEF_BEEP_ON  = 16;
  localparam int DEF_BEEP_OFF = 8;

  // Highest set enable wins; channel 3 has top priority.
  function automatic logic [1:0] sel_of(
    input logic [2:0] en
  );
    logic [1:0] s;
    if (en[2])      s = CH3;
    else if (en[1]) s = CH2;
    else if (en[0]) s = CH1;
    else            s = CH_NONE;
    return s;
  endfunction

endpackage

// File: rtl/buzzer_tone_driver_if.sv
// Enable/output bundle between the alarm FSM and the tone driver.
// master: drives buzz_en, observes spk/active/chan. slave: the driver.
interface buzzer_tone_driver_if;

  logic [2:0] buzz_en;
  logic       spk;
  logic       active;
  logic [1:0] chan;

  modport master (
    output buzz_en,
    input  spk,
    input  active,
    input  chan
  );

  modport slave (
    input  buzz_en,
    output spk,
    output active,
    output chan
  );

endinterface

// File: rtl/buzzer_tone_driver_tone_div.sv
// Half-period divider with toggle flop producing the tone square wave.
// Ports: clk, rst_n, clear (zero count and output), enable, half, sq.
module tone_div #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] half,
  output logic             sq
);

  logic [CNT_W-1:0] cnt_q;
  logic             last;

  assign last = (cnt_q == half - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq    <= 1'b0;
    end else if (clear) begin
      cnt_q <= '0;
      sq    <= 1'b0;
    end else if (enable) begin
      if (last) begin
        cnt_q <= '0;
        sq    <= ~sq;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/buzzer_tone_driver.sv
// Piezo driver: channel-pitched square wave gated by an on/off cadence.
// Ports: clk, rst_n, bus (slave: buzz_en in; spk, active, chan out).
module buzzer_tone_driver
  import buzzer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HALF1    = DEF_HALF1,
  parameter int HALF2    = DEF_HALF2,
  parameter int HALF3    = DEF_HALF3,
  parameter int BEEP_ON  = DEF_BEEP_ON,
  parameter int BEEP_OFF = DEF_BEEP_OFF
) (
  input logic clk,
  input logic rst_n,
  buzzer_tone_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF - 1);

  state_e           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [CNT_W-1:0] cad_q, cad_d;
  logic [1:0]       sel;
  logic [CNT_W-1:0] half;
  logic             tone_run;
  logic             sq;

  assign sel = sel_of(bus.buzz_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= CH_NONE;
      cad_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cad_q   <= cad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cad_d   = cad_q;
    unique case (state_q)
      IDLE: begin
        chan_d = CH_NONE;
        cad_d  = '0;
        if (sel != CH_NONE) begin
          state_d = ON;
          chan_d  = sel;
        end
      end
      ON, OFF: begin
        if (sel == CH_NONE) begin
          state_d = IDLE;
          chan_d  = CH_NONE;
          cad_d   = '0;
        end else if (sel != chan_q) begin
          state_d = ON;
          chan_d  = sel;
          cad_d   = '0;
        end else if (state_q == ON) begin
          if (cad_q == ON_LAST) begin
            state_d = OFF;
            cad_d   = '0;
          end else begin
            cad_d = cad_q + CNT_W'(1);
          end
        end else begin
          if (cad_q == OFF_LAST) begin
            state_d = ON;
            cad_d   = '0;
          end else begin
            cad_d = cad_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        chan_d  = CH_NONE;
        cad_d   = '0;
      end
    endcase
  end

  // Tone only advances while ON continues undisturbed; any entry,
  // exit or restart zeroes the divider so each beep starts in phase.
  assign tone_run = (state_q == ON) && (sel == chan_q)
                 && (cad_q != ON_LAST);

  always_comb begin
    half = '0;
    unique case (chan_q)
      CH1:     half = CNT_W'(HALF1);
      CH2:     half = CNT_W'(HALF2);
      CH3:     half = CNT_W'(HALF3);
      default: half = '0;
    endcase
  end

  tone_div #(
    .CNT_W (CNT_W)
  ) u_tone_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~tone_run),
    .enable (tone_run),
    .half   (half),
    .sq     (sq)
  );

  assign bus.spk    = sq;
  assign bus.active = (state_q != IDLE);
  assign bus.chan   = chan_q;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Self-checking bench for buzzer_tone_driver against a cadence model.
// Model tracks cycles since beep start and derives spk arithmetically.
module tb_buzzer_tone_driver;

  localparam int H1 = 3;
  localparam int H2 = 5;
  localparam int H3 = 7;
  localparam int BON = 16;
  localparam int BOFF = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  buzzer_tone_driver_if bus ();

  buzzer_tone_driver #(
    .CNT_W    (8),
    .HALF1    (H1),
    .HALF2    (H2),
    .HALF3    (H3),
    .BEEP_ON  (BON),
    .BEEP_OFF (BOFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit m_act;
  int m_ch;
  int m_k;

  function automatic void model_reset();
    m_act = 0;
    m_ch  = 0;
    m_k   = 0;
  endfunction

  function automatic void model_edge(input logic [2:0] en);
    int s;
    s = en[2] ? 3 : en[1] ? 2 : en[0] ? 1 : 0;
    if (s == 0) begin
      model_reset();
    end else if (!m_act || s != m_ch) begin
      m_act = 1;
      m_ch  = s;
      m_k   = 0;
    end else begin
      m_k++;
    end
  endfunction

  function automatic logic [3:0] model_out();
    int p;
    int h;
    logic s;
    if (!m_act) return 4'b0000;
    p = m_k % (BON + BOFF);
    h = (m_ch == 1) ? H1 : (m_ch == 2) ? H2 : H3;
    s = (p < BON) ? (((p / h) % 2) == 1) : 1'b0;
    return {s, 1'b1, 2'(m_ch)};
  endfunction

  function automatic logic [3:0] dut_out();
    return {bus.spk, bus.active, bus.chan};
  endfunction

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0;
    bus.buzz_en = 3'b111;
    model_reset();
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("FAIL reset_now got=%b exp=0000", got);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      got = dut_out();
      checks++;
      if (got !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=0000", got);
      end
    end
    @(negedge clk);
    bus.buzz_en = 3'b000;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      model_edge(3'b000);
      #1;
      got = dut_out();
      checks++;
      if (got !== model_out()) begin
        failures++;
        $display("FAIL reset_release got=%b exp=%b", got, model_out());
      end
    end
  endtask

  task automatic test_ch1_cadence();
    logic [3:0] got;
    logic [3:0] exp;
    for (int i = 0; i < 60; i++) begin
      bus.buzz_en = 3'b001;
      @(posedge clk);
      model_edge(3'b001);
      #1;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ch1_cadence edge=%0d got=%b exp=%b", i, got, exp);
      end
    end
    bus.buzz_en = 3'b000;
    @(posedge clk);
    model_edge(3'b000);
    #1;
  endtask

  task automatic test_priority();
    logic [3:0] got;
    logic [3:0] exp;
    for (int i = 0; i < 70; i++) begin
      bus.buzz_en = (i < 30) ? 3'b011 : 3'b110;
      @(posedge clk);
      model_edge(bus.buzz_en);
      #1;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL priority i=%0d got=%b exp=%b", i, got, exp);
      end
    end
    bus.buzz_en = 3'b000;
    @(posedge clk);
    model_edge(3'b000);
    #1;
  endtask

  task automatic test_mid_change();
    logic [3:0] got;
    logic [3:0] exp;
    for (int e = 0; e < 30; e++) begin
      bus.buzz_en = (e < 7) ? 3'b001 : 3'b100;
      @(posedge clk);
      model_edge(bus.buzz_en);
      #1;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mid_change edge=%0d got=%b exp=%b", e, got, exp);
      end
    end
    bus.buzz_en = 3'b000;
    @(posedge clk);
    model_edge(3'b000);
    #1;
  endtask

  task automatic test_release();
    logic [3:0] got;
    bus.buzz_en = 3'b001;
    repeat (4) begin
      @(posedge clk);
      model_edge(3'b001);
    end
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b1101) begin
      failures++;
      $display("FAIL release_pre got=%b exp=1101", got);
    end
    bus.buzz_en = 3'b000;
    @(posedge clk);
    model_edge(3'b000);
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("FAIL release got=%b exp=0000", got);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    bus.buzz_en = 3'b001;
    repeat (20) begin
      @(posedge clk);
      model_edge(3'b001);
    end
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b0101) begin
      failures++;
      $display("FAIL async_pre_off got=%b exp=0101", got);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got=%b exp=0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(3'b001);
    #1;
    got = dut_out();
    checks++;
    if (got !== 4'b0101) begin
      failures++;
      $display("FAIL async_reentry got=%b exp=0101", got);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      model_edge(3'b001);
      #1;
      got = dut_out();
      checks++;
      if (got !== model_out()) begin
        failures++;
        $display("FAIL async_after i=%0d got=%b exp=%b", i, got, model_out());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] got;
    logic [3:0] exp;
    logic [2:0] en;
    int hold;
    hold = 0;
    en = 3'b000;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        en = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 50);
      end
      hold--;
      bus.buzz_en = en;
      @(posedge clk);
      model_edge(en);
      #1;
      got = dut_out();
      exp = model_out();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random i=%0d en=%b got=%b exp=%b", i, en, got, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    test_reset();
    test_ch1_cadence();
    test_priority();
    test_mid_change();
    test_release();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
